// File: rtl/spi_reg_master_if.sv
// Request/response and SPI pin bundle for spi_reg_master.
// master = controller side, slave = requester / SPI peripheral side.
interface spi_reg_master_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [15:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [15:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        BUSY;
    logic        SPI_SCLK;
    logic        SPI_CS;
    logic        SPI_SDI;
    logic        SPI_SDO;

    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_WDATA, SPI_SDO,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY,
        output SPI_SCLK, SPI_CS, SPI_SDI
    );

    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_WDATA, SPI_SDO,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY,
        input  SPI_SCLK, SPI_CS, SPI_SDI
    );
endinterface

// File: rtl/spi_reg_master.sv
// SPI master sequencing 24-bit GET/PUT frames to spi_register.
// Define SPI_REG_MASTER_VERIFY_EN to add automatic readback after PUT.
module spi_reg_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    spi_reg_master_if.master bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
    localparam logic [7:0]    CMD_PUT  = 8'h46;
    localparam logic [7:0]    CMD_GET  = 8'h50;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP
    } state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_div;
    logic [GW-1:0] r_gap;
    logic [4:0]    r_bit;
    logic [22:0]   r_tx;
    logic [15:0]   r_rx;
    logic [15:0]   r_rdata;
    logic          r_write;
    logic          r_sclk;
    logic          r_cs;
    logic          r_sdi;
    logic          r_rsp_valid;
    logic          r_err;
    logic          w_tick;
    logic          w_accept;
    logic          w_rise;
    logic          w_fall;
    logic          w_done;
    logic          w_gap_end;
    logic          w_rb_pend;
    logic          w_upd;
    logic          w_err;

    assign w_tick = (r_div == DIV_LAST);

`ifdef SPI_REG_MASTER_VERIFY_EN
    logic          r_rb;
    logic [15:0]   r_wdata;

    // PUT frame done but readback not yet issued
    assign w_rb_pend = r_write & ~r_rb;
    assign w_upd     = ~r_write | r_rb;
    assign w_err     = r_rb & (r_rx != r_wdata);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rb    <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_rb    <= 1'b0;
            r_wdata <= bus.REQ_WDATA;
        end else if (w_gap_end & w_rb_pend) begin
            r_rb    <= 1'b1;
        end
    end
`else
    assign w_rb_pend = 1'b0;
    assign w_upd     = ~r_write;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_rise    = 1'b0;
        w_fall    = 1'b0;
        w_done    = 1'b0;
        w_gap_end = 1'b0;
        unique case (r_state)
            S_IDLE: if (bus.REQ_VALID) begin
                w_accept = 1'b1;
                w_next   = S_SETUP;
            end
            S_SETUP: if (w_tick) begin
                w_rise = 1'b1;
                w_next = S_SHIFT;
            end
            S_SHIFT: if (w_tick) begin
                if (r_sclk)               w_fall = 1'b1;
                else if (r_bit == 5'd24)  w_next = S_HOLD;
                else                      w_rise = 1'b1;
            end
            S_HOLD: if (w_tick) begin
                w_done = 1'b1;
                w_next = S_GAP;
            end
            S_GAP: if (w_tick && r_gap == GAP_LAST) begin
                w_gap_end = 1'b1;
                w_next    = w_rb_pend ? S_SETUP : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div       <= '0;
            r_gap       <= '0;
            r_bit       <= '0;
            r_tx        <= '1;
            r_rx        <= '0;
            r_rdata     <= '0;
            r_write     <= 1'b0;
            r_sclk      <= 1'b0;
            r_cs        <= 1'b1;
            r_sdi       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_div <= (r_state == S_IDLE || w_tick) ? '0 : r_div + DW'(1);
            if (r_state != S_GAP) r_gap <= '0;
            else if (w_tick)      r_gap <= r_gap + GW'(1);
            r_rsp_valid <= w_done & ~w_rb_pend;
            if (w_accept) begin
                r_write <= bus.REQ_WRITE;
                r_bit   <= '0;
                r_cs    <= 1'b0;
                r_sdi   <= bus.REQ_WRITE ? CMD_PUT[7] : CMD_GET[7];
                r_tx    <= bus.REQ_WRITE ? {CMD_PUT[6:0], bus.REQ_WDATA}
                                         : {CMD_GET[6:0], 16'hFFFF};
            end
            if (w_gap_end & w_rb_pend) begin
                r_bit <= '0;
                r_cs  <= 1'b0;
                r_sdi <= CMD_GET[7];
                r_tx  <= {CMD_GET[6:0], 16'hFFFF};
            end
            // rise number r_bit+1; data phase starts at rise 9
            if (w_rise) begin
                r_sclk <= 1'b1;
                r_bit  <= r_bit + 5'd1;
                if (r_bit >= 5'd8) r_rx <= {r_rx[14:0], bus.SPI_SDO};
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                r_sdi  <= r_tx[22];
                r_tx   <= {r_tx[21:0], 1'b1};
            end
            if (w_done) begin
                r_cs  <= 1'b1;
                r_sdi <= 1'b1;
                if (!w_rb_pend) begin
                    if (w_upd) r_rdata <= r_rx;
                    r_err <= w_err;
                end
            end
        end
    end

    assign bus.REQ_READY = (r_state == S_IDLE);
    assign bus.BUSY      = (r_state != S_IDLE);
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP_RDATA = r_rdata;
    assign bus.RSP_ERR   = r_err;
    assign bus.SPI_SCLK  = r_sclk;
    assign bus.SPI_CS    = r_cs;
    assign bus.SPI_SDI   = r_sdi;
endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: behavioural spi_register slave plus
// transaction-level expectations for timing, data and readback.
`timescale 1ns/1ps
module tb_spi_reg_master;
    localparam int H = 4;
    localparam int G = 2;
`ifdef SPI_REG_MASTER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    spi_reg_master_if bus ();
    spi_reg_master_if bus2 ();

    spi_reg_master #(.CLK_DIV(H), .CS_GAP(G)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );
    spi_reg_master #(.CLK_DIV(1), .CS_GAP(1)) dut2 (
        .CLK(clk), .RST(rst), .bus(bus2)
    );

    // behavioural slave, evaluated on settled values each negedge
    logic [15:0] s_reg = 16'hABCD;
    logic [23:0] s_sh = '0;
    logic [7:0]  s_cmd = '0;
    int          s_fall = 0;
    logic        s_sdi_q = 1'b1;
    logic        s_sdo = 1'b1;
    logic        sdo_force = 1'b0;
    logic        p_cs = 1'b1;
    logic        p_sclk = 1'b0;
    logic [7:0]  s_cmds[$];
    logic [15:0] s_wr[$];

    assign bus.SPI_SDO  = sdo_force ? 1'b1 : s_sdo;
    assign bus2.SPI_SDO = 1'b0;

    always @(negedge clk) begin
        if (p_cs && !bus.SPI_CS) begin
            s_fall = 0;
            s_sh   = '0;
            s_cmd  = '0;
        end
        if (!p_cs && bus.SPI_CS) s_sdo = 1'b1;
        if (!bus.SPI_CS && !p_sclk && bus.SPI_SCLK) s_sdi_q = bus.SPI_SDI;
        if (!bus.SPI_CS && p_sclk && !bus.SPI_SCLK) begin
            s_sh = {s_sh[22:0], s_sdi_q};
            s_fall++;
            if (s_fall == 8) begin
                s_cmd = s_sh[7:0];
                s_cmds.push_back(s_sh[7:0]);
            end
            if (s_fall >= 8 && s_fall < 24 && s_cmd == 8'h50)
                s_sdo = s_reg[23-s_fall];
            if (s_fall == 24 && s_cmd == 8'h46) begin
                s_reg = s_sh[15:0];
                s_wr.push_back(s_sh[15:0]);
            end
        end
        p_cs   = bus.SPI_CS;
        p_sclk = bus.SPI_SCLK;
    end

    // reference state: slave register content and last RSP_RDATA
    logic [15:0] model_reg = 16'hABCD;
    logic [15:0] last_rd = 16'h0000;

    int          t_lat, t_cs, t_pulse, t_rdy;
    logic [15:0] t_rd;
    logic        t_err, t_to;

    task automatic do_txn(input logic wr, input logic [15:0] wd);
        int a;
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.REQ_READY && n < 2000) begin
            @(negedge clk);
            n++;
        end
        bus.REQ_VALID = 1'b1;
        bus.REQ_WRITE = wr;
        bus.REQ_WDATA = wd;
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        bus.REQ_WRITE = ~wr;
        bus.REQ_WDATA = ~wd;
        a = cyc;
        t_cs = 0;
        t_pulse = 0;
        t_lat = -1;
        t_rdy = -1;
        t_rd = 'x;
        t_err = 1'bx;
        t_to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!bus.SPI_CS) t_cs++;
            if (bus.RSP_VALID) begin
                t_pulse++;
                if (t_lat < 0) begin
                    t_lat = cyc - a;
                    t_rd  = bus.RSP_RDATA;
                    t_err = bus.RSP_ERR;
                end
            end
            if (bus.REQ_READY) begin
                t_rdy = cyc - a;
                t_to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (t_to) begin
            errors++;
            $display("FAIL txn_timeout ready never returned wr=%0b", wr);
        end
    endtask

    function automatic int exp_lat(input logic wr);
        return (VER && wr) ? (100 + G) * H : 50 * H;
    endfunction

    function automatic int exp_cs(input logic wr);
        return (VER && wr) ? 100 * H : 50 * H;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.SPI_CS, bus.SPI_SCLK, bus.SPI_SDI} !== 3'b101) begin
            errors++;
            $display("FAIL reset_spi got %b exp 101",
                     {bus.SPI_CS, bus.SPI_SCLK, bus.SPI_SDI});
        end
        checks++;
        if ({bus.REQ_READY, bus.BUSY, bus.RSP_VALID, bus.RSP_ERR} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 1000",
                     {bus.REQ_READY, bus.BUSY, bus.RSP_VALID, bus.RSP_ERR});
        end
        checks++;
        if (bus.RSP_RDATA !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata got %h exp 0000", bus.RSP_RDATA);
        end
        rst = 1'b0;
        last_rd = 16'h0000;
    endtask

    task automatic test_get_fresh();
        s_cmds.delete();
        do_txn(1'b0, 16'($urandom));
        checks++;
        if (t_rd !== 16'hABCD) begin
            errors++;
            $display("FAIL fresh_get_data got %h exp abcd", t_rd);
        end
        checks++;
        if (t_pulse !== 1) begin
            errors++;
            $display("FAIL fresh_get_pulses got %0d exp 1", t_pulse);
        end
        checks++;
        if (t_cs !== 50 * H) begin
            errors++;
            $display("FAIL fresh_get_cs_low got %0d exp %0d", t_cs, 50 * H);
        end
        checks++;
        if (t_lat !== 50 * H) begin
            errors++;
            $display("FAIL fresh_get_latency got %0d exp %0d", t_lat, 50 * H);
        end
        checks++;
        if (t_rdy !== (50 + G) * H) begin
            errors++;
            $display("FAIL fresh_get_ready got %0d exp %0d", t_rdy, (50 + G) * H);
        end
        checks++;
        if (t_err !== 1'b0) begin
            errors++;
            $display("FAIL fresh_get_err got %b exp 0", t_err);
        end
        checks++;
        if (s_cmds.size() != 1 || s_cmds[0] !== 8'h50) begin
            errors++;
            $display("FAIL fresh_get_cmd got n=%0d exp one 50", s_cmds.size());
        end
        last_rd = 16'hABCD;
    endtask

    task automatic test_put_get();
        logic [15:0] d = 16'h1234;
        logic [15:0] e;
        s_cmds.delete();
        s_wr.delete();
        do_txn(1'b1, d);
        model_reg = d;
        e = VER ? d : last_rd;
        last_rd = e;
        checks++;
        if (s_cmds.size() == 0 || s_cmds[0] !== 8'h46) begin
            errors++;
            $display("FAIL put_cmd got n=%0d exp first 46", s_cmds.size());
        end
        checks++;
        if (s_wr.size() != 1 || s_wr[0] !== d) begin
            errors++;
            $display("FAIL put_wire_data got n=%0d exp %h captured", s_wr.size(), d);
        end
        checks++;
        if (t_rd !== e || t_pulse !== 1 || t_lat !== exp_lat(1'b1)) begin
            errors++;
            $display("FAIL put_rsp got rd=%h p=%0d lat=%0d exp rd=%h p=1 lat=%0d",
                     t_rd, t_pulse, t_lat, e, exp_lat(1'b1));
        end
        checks++;
        if (t_cs !== exp_cs(1'b1)) begin
            errors++;
            $display("FAIL put_cs_low got %0d exp %0d", t_cs, exp_cs(1'b1));
        end
        s_cmds.delete();
        do_txn(1'b0, 16'h0000);
        last_rd = model_reg;
        checks++;
        if (t_rd !== 16'h1234 || s_cmds.size() == 0 || s_cmds[0] !== 8'h50) begin
            errors++;
            $display("FAIL put_then_get got rd=%h exp 1234 with cmd 50", t_rd);
        end
    endtask

    task automatic test_random();
        logic        wr;
        logic [15:0] wd;
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            wr = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            s_cmds.delete();
            s_wr.delete();
            do_txn(wr, wd);
            if (wr) begin
                model_reg = wd;
                e = VER ? wd : last_rd;
            end else begin
                e = model_reg;
            end
            last_rd = e;
            checks++;
            if (t_rd !== e || t_pulse !== 1 || t_err !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d rsp got rd=%h p=%0d err=%b exp rd=%h p=1 err=0",
                         i, t_rd, t_pulse, t_err, e);
            end
            checks++;
            if (t_lat !== exp_lat(wr) || t_rdy !== exp_lat(wr) + G * H) begin
                errors++;
                $display("FAIL rand_%0d timing got lat=%0d rdy=%0d exp %0d %0d",
                         i, t_lat, t_rdy, exp_lat(wr), exp_lat(wr) + G * H);
            end
            checks++;
            if (s_cmds.size() == 0 || s_cmds[0] !== (wr ? 8'h46 : 8'h50)) begin
                errors++;
                $display("FAIL rand_%0d cmd got n=%0d exp wr=%0b", i, s_cmds.size(), wr);
            end
            if (wr) begin
                checks++;
                if (s_wr.size() != 1 || s_wr[0] !== wd) begin
                    errors++;
                    $display("FAIL rand_%0d wire_data exp %h", i, wd);
                end
            end
        end
    endtask

    int acc_q[$];
    always @(posedge clk)
        if (bus2.REQ_VALID && bus2.REQ_READY) acc_q.push_back(cyc);

    task automatic test_back_to_back();
        int idle;
        int n;
        acc_q.delete();
        idle = 0;
        n = 0;
        @(negedge clk);
        bus2.REQ_VALID = 1'b1;
        bus2.REQ_WRITE = 1'b0;
        bus2.REQ_WDATA = 16'h0000;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (acc_q.size() >= 3) break;
            if (!bus2.BUSY) idle++;
        end
        bus2.REQ_VALID = 1'b0;
        checks++;
        if (acc_q.size() < 3) begin
            errors++;
            $display("FAIL b2b_accepts got %0d exp 3", acc_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_q[i] - acc_q[i-1] !== 52) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d got %0d exp 52", i,
                             acc_q[i] - acc_q[i-1]);
                end
            end
        end
        checks++;
        if (idle !== 2) begin
            errors++;
            $display("FAIL b2b_idle_cycles got %0d exp 2", idle);
        end
    endtask

    task automatic test_reset_mid();
        int   rises;
        int   n;
        int   pulses;
        logic prev;
        logic [15:0] keep = model_reg;
        rises = 0;
        n = 0;
        pulses = 0;
        @(negedge clk);
        while (!bus.REQ_READY && n < 2000) begin
            @(negedge clk);
            n++;
        end
        bus.REQ_VALID = 1'b1;
        bus.REQ_WRITE = 1'b1;
        bus.REQ_WDATA = 16'h5555;
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        n = 0;
        prev = bus.SPI_SCLK;
        while (rises < 12 && n < 1000) begin
            @(negedge clk);
            n++;
            if (bus.SPI_SCLK && !prev) rises++;
            prev = bus.SPI_SCLK;
        end
        checks++;
        if (rises != 12) begin
            errors++;
            $display("FAIL rstmid_reach_sclk12 got %0d exp 12", rises);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.SPI_CS !== 1'b1 || bus.SPI_SCLK !== 1'b0 || bus.REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_abort got cs=%b sclk=%b rdy=%b exp 1 0 1",
                     bus.SPI_CS, bus.SPI_SCLK, bus.REQ_READY);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.RSP_VALID) pulses++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.RSP_VALID) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rstmid_no_rsp got %0d exp 0", pulses);
        end
        last_rd = 16'h0000;
        do_txn(1'b0, 16'h0000);
        last_rd = keep;
        checks++;
        if (t_rd !== keep) begin
            errors++;
            $display("FAIL rstmid_get got %h exp %h", t_rd, keep);
        end
    endtask

`ifdef SPI_REG_MASTER_VERIFY_EN
    task automatic test_verify();
        s_cmds.delete();
        do_txn(1'b1, 16'hBEEF);
        model_reg = 16'hBEEF;
        checks++;
        if (t_pulse !== 1 || t_rd !== 16'hBEEF || t_err !== 1'b0) begin
            errors++;
            $display("FAIL verify_ok got p=%0d rd=%h err=%b exp 1 beef 0",
                     t_pulse, t_rd, t_err);
        end
        checks++;
        if (s_cmds.size() != 2 || s_cmds[1] !== 8'h50) begin
            errors++;
            $display("FAIL verify_frames got n=%0d exp 2 frames", s_cmds.size());
        end
        sdo_force = 1'b1;
        do_txn(1'b1, 16'h1357);
        sdo_force = 1'b0;
        model_reg = 16'h1357;
        checks++;
        if (t_pulse !== 1 || t_rd !== 16'hFFFF || t_err !== 1'b1) begin
            errors++;
            $display("FAIL verify_bad got p=%0d rd=%h err=%b exp 1 ffff 1",
                     t_pulse, t_rd, t_err);
        end
        do_txn(1'b0, 16'h0000);
        checks++;
        if (t_rd !== 16'h1357 || t_err !== 1'b0) begin
            errors++;
            $display("FAIL verify_get got rd=%h err=%b exp 1357 0", t_rd, t_err);
        end
    endtask
`endif

    initial begin
        bus.REQ_VALID  = 1'b0;
        bus.REQ_WRITE  = 1'b0;
        bus.REQ_WDATA  = '0;
        bus2.REQ_VALID = 1'b0;
        bus2.REQ_WRITE = 1'b0;
        bus2.REQ_WDATA = '0;
        test_reset();
        test_get_fresh();
        test_put_get();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_REG_MASTER_VERIFY_EN
        test_verify();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI master controller that sequences 16-bit GET/PUT transactions to the team's `spi_register` SPI slave from a system-clock request/response interface. It generates SPI_SCLK, SPI_CS and SPI_SDI, shifts in SPI_SDO, and accepts one request at a time. It sits between on-chip logic (CPU bus bridge or test sequencer) and the external/peripheral SPI register.

## Interface
- CLK_DIV, 4, CLK cycles per SPI_SCLK half-period (H); legal ≥1.
- CS_GAP, 2, minimum SPI_CS-high time between transactions, in half-periods; legal ≥1.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller idle, can accept.
- REQ_WRITE  in  1  1 = PUT (cmd 0x46), 0 = GET (cmd 0x50).
- REQ_WDATA  in  16  write data, MSB first on wire.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  16  read data (GET, or readback when verify is compiled in).
- RSP_ERR  out  1  readback mismatch; valid with RSP_VALID.
- BUSY  out  1  transaction in progress (not IDLE).
- SPI_SCLK  out  1  serial clock, idle low.
- SPI_CS  out  1  chip select, active low, idle high.
- SPI_SDI  out  1  master data to slave, idle high.
- SPI_SDO  in  1  slave data to master.

## Operation
- Handshake: transfer on REQ_VALID & REQ_READY. REQ_WRITE and REQ_WDATA are captured then; later changes are ignored. REQ_READY = (state == IDLE).
- Frame: 24 SCLK periods. 8 command bits MSB first, then 16 data bits.
- Write frame: data bits come from captured REQ_WDATA[15:0]. Read frame: SPI_SDI is held 1 during the data bits.
- The slave samples SPI_SDI on the SCLK falling edge. Bit k is driven from the preceding falling edge (or SETUP for bit 1) until falling edge k.
- GET sampling: SPI_SDO is sampled on rising edges 9..24 into a shift register, MSB first. Rising edge 9 yields d[15]; rising edge 24 yields d[0].
- States:
  - IDLE: CS=1, SCLK=0, SDI=1.
  - SETUP: CS=0, SDI=cmd[7], H cycles.
  - SHIFT: 24 SCLK periods, each H cycles high then H cycles low; ends on the 24th falling edge.
  - HOLD: CS=0, SCLK=0, H cycles.
  - GAP: CS=1, CS_GAP·H cycles.
  - Transitions: IDLE→SETUP on accept; SETUP→SHIFT; SHIFT→HOLD; HOLD→GAP; GAP→IDLE.
- On entry to GAP: RSP_VALID pulses for one cycle.
  - GET: RSP_RDATA is updated with the shifted value.
  - PUT: RSP_RDATA is unchanged.
- RSP_ERR is 0 unless verify is enabled.
- Counters: a half-period divider counts 0..H-1, and a 5-bit bit counter counts 1..24. No wrap beyond 24.
- Reset values: SPI_CS=1, SPI_SCLK=0, SPI_SDI=1, REQ_READY=1, BUSY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, state=IDLE.
- RST mid-transaction: the frame is aborted immediately and CS goes high, which resets the slave. No RSP_VALID is issued. A partial PUT is not committed beyond bits the slave already latched.

## Timing
- Accept at cycle T. SPI_CS falls at T+1.
- First SCLK rising edge occurs at T+1+H.
- SPI_CS is low for 50·H cycles (SETUP H + SHIFT 48H + HOLD H).
- RSP_VALID is asserted at T+1+50H, the same cycle SPI_CS rises.
- REQ_READY reasserts at T+1+50H+CS_GAP·H.
- Back-to-back requests: minimum period is 1+50H+CS_GAP·H cycles.
- All SPI outputs are registered; no combinational path from REQ_* to SPI_*.
- REQ_VALID held during BUSY is not accepted; it is accepted on the first IDLE cycle.

## Configuration
- SPI_REG_MASTER_VERIFY_EN defined:
  - Every PUT is followed, after the GAP, by an automatic GET frame (no REQ_READY in between).
  - RSP_VALID fires once, after the readback frame.
  - RSP_RDATA = readback value; RSP_ERR = (readback != written data).
  - GET requests behave as normal, with RSP_ERR=0.
- Undefined: PUT is a single frame, RSP_ERR is tied 0, and the readback logic is absent.

## Test plan
- Slave fresh from init, CLK_DIV=4, GET → RSP_RDATA=0xABCD, RSP_VALID one cycle, SPI_CS low exactly 200 CLK cycles.
- PUT 0x1234, then GET → RSP_RDATA=0x1234. SPI_SDI over the first 8 falling edges reads 0x46, then 0x50 on the GET.
- CLK_DIV=1, CS_GAP=1, REQ_VALID held high for 3 requests → accepts spaced 52 cycles apart, REQ_READY low in between.
- RST pulsed at the 12th SCLK of a PUT 0x5555 → SPI_CS=1 immediately, no RSP_VALID. Subsequent GET returns the prior register value, not 0x5555.
- VERIFY_EN defined, PUT 0xBEEF → one RSP_VALID after two frames, RSP_RDATA=0xBEEF, RSP_ERR=0. Repeat with SPI_SDO forced 1 → RSP_RDATA=0xFFFF, RSP_ERR=1.
- REQ_WDATA changed the cycle after accept → wire carries the originally captured value.
